fetch_decode: RTL and testbench



---
 rtl/cpu_pkg.sv | 26 ++
 rtl/instr_fields.sv | 21 ++
 rtl/fetch_decode.sv | 115 +++++++++++
 tb/tb_fetch_decode.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU front end: word/field geometry,
// the HALT opcode and the fetch/decode state encoding.
package cpu_pkg;

    localparam int WORD_W  = 16;
    localparam int OP_W    = 5;

    // Instruction word layout: [15:11] op, [10] sel_imm, [9:7] rd, [6:4] rs
    localparam int OP_LSB  = 11;
    localparam int SEL_BIT = 10;
    localparam int RD_MSB  = 9;
    localparam int RD_LSB  = 7;
    localparam int RS_MSB  = 6;
    localparam int RS_LSB  = 4;
    localparam int REG_W   = RD_MSB - RD_LSB + 1;

    localparam logic [OP_W-1:0] OP_HALT = 5'b11111;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        ISSUE     = 2'd2,
        HALTED    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fields.sv
// Pure combinational split of an instruction word into its decode fields.
module instr_fields
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [OP_W-1:0]   op,
    output logic              sel_imm,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rs
);

    // Low bits carry no field today; fold them so they are visibly consumed.
    logic unused_low;

    assign op         = word[OP_LSB +: OP_W];
    assign sel_imm    = word[SEL_BIT];
    assign rd         = word[RD_MSB:RD_LSB];
    assign rs         = word[RS_MSB:RS_LSB];
    assign unused_low = ^word[RS_LSB-1:0];

endmodule

// File: rtl/fetch_decode.sv
// Fetch and field-decode stage: owns the PC, fetches an opcode word and an
// optional immediate word, then presents one registered bundle downstream.
// Fetch and issue never overlap, so at most one instruction is in flight.
module fetch_decode #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          WORD_W   = 16,
    parameter int          OP_W     = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_mem_req,
    output logic [WORD_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [WORD_W-1:0] i_mem_data,
    input  logic              i_redirect,
    input  logic [WORD_W-1:0] i_redirect_addr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OP_W-1:0]   o_op,
    output logic              o_sel_imm,
    output logic [2:0]        o_rd,
    output logic [2:0]        o_rs,
    output logic [WORD_W-1:0] o_imm,
    output logic              o_halted
);

    import cpu_pkg::*;

    fetch_state_t      state;
    logic [WORD_W-1:0] pc;
    logic              xfer;

    logic [OP_W-1:0]   f_op;
    logic              f_sel;
    logic [2:0]        f_rd;
    logic [2:0]        f_rs;

    instr_fields u_fields (
        .word    (i_mem_data),
        .op      (f_op),
        .sel_imm (f_sel),
        .rd      (f_rd),
        .rs      (f_rs)
    );

    // Requests are suppressed during reset and in a redirect cycle so no
    // transfer can land on a PC that is about to be replaced.
    assign o_mem_req  = i_rst_n && !i_redirect &&
                        ((state == FETCH_OP) || (state == FETCH_IMM));
    assign o_mem_addr = pc;
    assign xfer       = o_mem_req && i_mem_ack;

    // Fetch/issue FSM; redirect outranks everything but reset and discards
    // any half-fetched or un-accepted instruction.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= FETCH_OP;
            pc        <= RESET_PC;
            o_valid   <= 1'b0;
            o_halted  <= 1'b0;
            o_op      <= '0;
            o_sel_imm <= 1'b0;
            o_rd      <= '0;
            o_rs      <= '0;
            o_imm     <= '0;
        end else if (i_redirect) begin
            state    <= FETCH_OP;
            pc       <= i_redirect_addr;
            o_valid  <= 1'b0;
            o_halted <= 1'b0;
        end else begin
            case (state)
                FETCH_OP: begin
                    if (xfer) begin
                        o_op      <= f_op;
                        o_sel_imm <= f_sel;
                        o_rd      <= f_rd;
                        o_rs      <= f_rs;
                        pc        <= pc + WORD_W'(1);
                        if (f_sel) begin
                            state <= FETCH_IMM;
                        end else begin
                            o_imm   <= '0;
                            o_valid <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                FETCH_IMM: begin
                    if (xfer) begin
                        o_imm   <= i_mem_data;
                        pc      <= pc + WORD_W'(1);
                        o_valid <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (o_op == OP_HALT) begin
                            o_halted <= 1'b1;
                            state    <= HALTED;
                        end else begin
                            state <= FETCH_OP;
                        end
                    end
                end
                default: begin
                    // HALTED: parked until reset or redirect.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: an instruction-level model (expected fetch
// address, partially assembled instruction, expected issued bundle) checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_decode;

    localparam logic [15:0] RPC = 16'h0100;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        valid;
    logic        ready;
    logic [4:0]  op;
    logic        sel_imm;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] imm;
    logic        halted;

    logic [15:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    fetch_decode #(.RESET_PC(RPC), .WORD_W(16), .OP_W(5)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .o_mem_req       (mem_req),
        .o_mem_addr      (mem_addr),
        .i_mem_ack       (mem_ack),
        .i_mem_data      (mem_data),
        .i_redirect      (redirect),
        .i_redirect_addr (redirect_addr),
        .o_valid         (valid),
        .i_ready         (ready),
        .o_op            (op),
        .o_sel_imm       (sel_imm),
        .o_rd            (rd),
        .o_rs            (rs),
        .o_imm           (imm),
        .o_halted        (halted)
    );

    assign mem_data = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    logic [15:0] m_pc     = RPC;
    logic        m_pend   = 1'b0;   // opcode word taken, immediate outstanding
    logic [15:0] m_word   = '0;
    logic        m_valid  = 1'b0;
    logic [15:0] m_imm    = '0;
    logic        m_halted = 1'b0;

    always @(negedge clk) begin
        logic exp_req;
        exp_req = rst_n && !redirect && !m_valid && !m_halted;
        chk("m_valid", valid, m_valid);
        chk("m_halted", halted, m_halted);
        chk("m_req", mem_req, exp_req);
        if (exp_req) chk("m_addr", mem_addr, m_pc);
        if (m_valid) begin
            chk("m_op",  op,      m_word[15:11]);
            chk("m_sel", sel_imm, m_word[10]);
            chk("m_rd",  rd,      m_word[9:7]);
            chk("m_rs",  rs,      m_word[6:4]);
            chk("m_imm", imm,     m_imm);
        end
        // What the next rising edge does, in instruction terms.
        if (!rst_n) begin
            m_pc = RPC; m_pend = 0; m_valid = 0; m_halted = 0;
        end else if (redirect) begin
            m_pc = redirect_addr; m_pend = 0; m_valid = 0; m_halted = 0;
        end else if (exp_req && mem_ack) begin
            if (m_pend) begin
                m_imm = mem_data; m_pend = 0; m_valid = 1;
            end else begin
                m_word = mem_data;
                if (mem_data[10]) m_pend = 1;
                else begin m_imm = '0; m_valid = 1; end
            end
            m_pc = m_pc + 16'd1;
        end else if (m_valid && ready) begin
            m_valid = 0;
            if (m_word[15:11] == 5'b11111) m_halted = 1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0100] = 16'h1950;   // op 3, rd 2, rs 5
        mem[16'h0101] = 16'h2480;   // op 4, sel, rd 1
        mem[16'h0102] = 16'hBEEF;
        mem[16'h0103] = 16'h2480;
        mem[16'h0104] = 16'hAAAA;
        mem[16'h0040] = 16'h0800;
        mem[16'hFFFF] = 16'h2C00;   // op 5, sel
        mem[16'h0000] = 16'h1234;
        mem[16'h0001] = 16'hF800;   // HALT
        mem[16'h0200] = 16'h0B10;   // op 1, rd 6, rs 1
        mem[16'h0201] = 16'h2480;

        rst_n = 0; mem_ack = 0; ready = 0; redirect = 0; redirect_addr = '0;
        tick;
        chk("rst_req", mem_req, 0);
        chk("rst_valid", valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_op", op, 0);
        chk("rst_imm", imm, 0);
        tick;
        rst_n = 1; #1;
        chk("boot_req", mem_req, 1);
        chk("boot_addr", mem_addr, 16'h0100);
        tick;

        // 1-word instruction, held through back-pressure
        mem_ack = 1; tick; mem_ack = 0;
        chk("w1_valid", valid, 1);
        chk("w1_op", op, 3);
        chk("w1_sel", sel_imm, 0);
        chk("w1_rd", rd, 2);
        chk("w1_rs", rs, 5);
        chk("w1_imm", imm, 0);
        repeat (3) begin
            tick;
            chk("w1_hold_valid", valid, 1);
            chk("w1_hold_op", op, 3);
        end
        ready = 1; tick; ready = 0; #1;
        chk("w1_next_valid", valid, 0);
        chk("w1_next_addr", mem_addr, 16'h0101);

        // 2-word instruction
        mem_ack = 1; tick; tick; mem_ack = 0;
        chk("w2_valid", valid, 1);
        chk("w2_op", op, 4);
        chk("w2_sel", sel_imm, 1);
        chk("w2_rd", rd, 1);
        chk("w2_imm", imm, 16'hBEEF);
        ready = 1; tick; ready = 0; #1;
        chk("w2_next_addr", mem_addr, 16'h0103);

        // redirect while the immediate is outstanding, ack also high
        mem_ack = 1; tick;
        redirect = 1; redirect_addr = 16'h0040; #1;
        chk("rd_no_req", mem_req, 0);
        tick; redirect = 0; mem_ack = 0; #1;
        chk("rd_valid", valid, 0);
        chk("rd_req", mem_req, 1);
        chk("rd_addr", mem_addr, 16'h0040);
        tick;

        // 2-word instruction straddling the top of memory
        redirect = 1; redirect_addr = 16'hFFFF; tick; redirect = 0;
        mem_ack = 1; tick; tick; mem_ack = 0;
        chk("wrap_op", op, 5);
        chk("wrap_imm", imm, 16'h1234);
        ready = 1; tick; ready = 0; #1;
        chk("wrap_next_addr", mem_addr, 16'h0001);

        // HALT, then wake by redirect
        mem_ack = 1; tick; mem_ack = 0;
        chk("halt_op", op, 5'h1F);
        ready = 1; tick; ready = 0; #1;
        chk("halt_flag", halted, 1);
        mem_ack = 1;
        repeat (10) begin
            tick;
            chk("halt_req", mem_req, 0);
            chk("halt_hold", halted, 1);
        end
        mem_ack = 0;
        redirect = 1; redirect_addr = 16'h0200; tick; redirect = 0; #1;
        chk("wake_halted", halted, 0);
        chk("wake_req", mem_req, 1);
        chk("wake_addr", mem_addr, 16'h0200);
        mem_ack = 1; tick; mem_ack = 0;
        chk("wake_op", op, 1);
        chk("wake_rd", rd, 6);
        chk("wake_rs", rs, 1);
        ready = 1; tick; ready = 0;

        // reset in the middle of a 2-word fetch
        mem_ack = 1; tick;
        rst_n = 0; tick;
        rst_n = 1; mem_ack = 0; #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_req", mem_req, 1);
        chk("mid_rst_addr", mem_addr, 16'h0100);
        tick; tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
